// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, divider state encoding and the register-match helper
// used by the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int REG_W          = 5;
  localparam int DIV_CYCLES_DEF = 32;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } divState_t;

  // True when a stage writes a non-zero register that matches the source.
  function automatic logic regHit(input logic we, input logic [REG_W-1:0] wr,
                                  input logic [REG_W-1:0] src);
    return we && (wr != '0) && (wr == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller: decoder/stage
// information in, forwarding selects and stall/flush controls out.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [REG_W-1:0] rsD, rtD, rsE, rtE;
  logic [REG_W-1:0] write_regE, write_regM, write_regW;
  logic             branchD;
  logic             reg_write_enE, reg_write_enM, reg_write_enW;
  logic             mem_to_regE, mem_to_regM;
  logic             div_startE, except_M, i_stall, d_stall;

  logic [1:0]       forward_aE, forward_bE;
  logic             forward_aD, forward_bD;
  logic             stallF, stallD, stallE, stallM, stallW;
  logic             flushD, flushE, flushM, flushW;
  logic             div_busy, div_done;

  modport master (
    output rsD, rtD, rsE, rtE, write_regE, write_regM, write_regW, branchD,
           reg_write_enE, reg_write_enM, reg_write_enW, mem_to_regE,
           mem_to_regM, div_startE, except_M, i_stall, d_stall,
    input  forward_aE, forward_bE, forward_aD, forward_bD,
           stallF, stallD, stallE, stallM, stallW,
           flushD, flushE, flushM, flushW, div_busy, div_done
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, write_regE, write_regM, write_regW, branchD,
           reg_write_enE, reg_write_enM, reg_write_enW, mem_to_regE,
           mem_to_regM, div_startE, except_M, i_stall, d_stall,
    output forward_aE, forward_bE, forward_aD, forward_bD,
           stallF, stallD, stallE, stallM, stallW,
           flushD, flushE, flushM, flushW, div_busy, div_done
  );
endinterface

// File: rtl/hazard_ctrl_div_seq.sv
// Divider sequencer: counts the EX occupancy of a div/divu and holds the
// result-valid state until EX advances.
module div_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic advance,
  output logic busy,
  output logic done
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  divState_t        state, stateNxt;
  logic [CNT_W-1:0] cnt, cntNxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  // Abort wins over everything so an exception never leaves a stale count.
  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    if (abort) begin
      stateNxt = DIV_IDLE;
      cntNxt   = '0;
    end else begin
      unique case (state)
        DIV_IDLE: if (start) begin
          stateNxt = DIV_BUSY;
          cntNxt   = CNT_W'(DIV_CYCLES - 1);
        end
        DIV_BUSY: if (cnt == '0) stateNxt = DIV_DONE;
                  else           cntNxt   = cnt - CNT_W'(1);
        DIV_DONE: if (advance) stateNxt = DIV_IDLE;
        default:  stateNxt = DIV_IDLE;
      endcase
    end
  end

  assign busy = (state == DIV_BUSY);
  assign done = (state == DIV_DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the five-stage core: operand forwarding,
// load-use and branch stalls, memory-wait stalls, divider holds and flushes.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  logic flushPending;
  logic divBusy, divDone, divIdle;
  logic memStall, lwStall, brStall, divStall;
  logic stallF, stallD, stallE, stallM, stallW;
  logic flushD, flushE, flushM, flushW;
  logic [1:0] fwdAE, fwdBE;
  logic fwdAD, fwdBD;

  div_seq #(.DIV_CYCLES(DIV_CYCLES)) uDivSeq (
    .clk     (clk),
    .rst     (rst),
    .start   (bus.div_startE),
    .abort   (bus.except_M),
    .advance (~stallE),
    .busy    (divBusy),
    .done    (divDone)
  );

  // A fetch still outstanding at exception time delays the ID flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                flushPending <= 1'b0;
    else if (bus.except_M)  flushPending <= bus.i_stall;
    else if (!bus.i_stall)  flushPending <= 1'b0;
  end

  assign divIdle  = ~divBusy & ~divDone;
  assign memStall = bus.i_stall | bus.d_stall;
  assign divStall = divBusy | (divIdle & bus.div_startE);
  assign lwStall  = bus.mem_to_regE &
                    (regHit(bus.reg_write_enE, bus.write_regE, bus.rsD) |
                     regHit(bus.reg_write_enE, bus.write_regE, bus.rtD));
  assign brStall  = bus.branchD &
                    (regHit(bus.reg_write_enE, bus.write_regE, bus.rsD) |
                     regHit(bus.reg_write_enE, bus.write_regE, bus.rtD) |
                     regHit(bus.mem_to_regM,   bus.write_regM, bus.rsD) |
                     regHit(bus.mem_to_regM,   bus.write_regM, bus.rtD));

  always_comb begin
    fwdAE = FWD_REG;
    fwdBE = FWD_REG;
    fwdAD = 1'b0;
    fwdBD = 1'b0;
    if (!rst) begin
      if (regHit(bus.reg_write_enM, bus.write_regM, bus.rsE))      fwdAE = FWD_M;
      else if (regHit(bus.reg_write_enW, bus.write_regW, bus.rsE)) fwdAE = FWD_W;
      if (regHit(bus.reg_write_enM, bus.write_regM, bus.rtE))      fwdBE = FWD_M;
      else if (regHit(bus.reg_write_enW, bus.write_regW, bus.rtE)) fwdBE = FWD_W;
      fwdAD = regHit(bus.reg_write_enM, bus.write_regM, bus.rsD);
      fwdBD = regHit(bus.reg_write_enM, bus.write_regM, bus.rtD);
    end
  end

  // Priority: exception, memory wait, divider, load-use/branch.
  always_comb begin
    {stallF, stallD, stallE, stallM, stallW} = '0;
    {flushD, flushE, flushM, flushW}         = '0;
    if (!rst) begin
      if (bus.except_M) begin
        {flushE, flushM, flushW} = 3'b111;
        flushD = ~bus.i_stall;
        stallF = bus.i_stall;
        stallD = bus.i_stall;
      end else begin
        if (memStall) begin
          {stallF, stallD, stallE, stallM, stallW} = 5'b11111;
        end else if (divStall) begin
          {stallF, stallD, stallE} = 3'b111;
          flushM = 1'b1;
        end else if (lwStall | brStall) begin
          {stallF, stallD} = 2'b11;
          flushE = 1'b1;
        end
        if (flushPending && !bus.i_stall) begin
          flushD = 1'b1;
          stallD = 1'b0;
        end
      end
    end
  end

  assign bus.forward_aE = fwdAE;
  assign bus.forward_bE = fwdBE;
  assign bus.forward_aD = fwdAD;
  assign bus.forward_bD = fwdBD;
  assign bus.stallF     = stallF;
  assign bus.stallD     = stallD;
  assign bus.stallE     = stallE;
  assign bus.stallM     = stallM;
  assign bus.stallW     = stallW;
  assign bus.flushD     = flushD;
  assign bus.flushE     = flushE;
  assign bus.flushM     = flushM;
  assign bus.flushW     = flushW;
  assign bus.div_busy   = divBusy & ~rst;
  assign bus.div_done   = divDone & ~rst;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a timeline-based
// reference model of forwarding, stall, flush and divider behaviour.
module tb_hazard_ctrl;

  localparam int DIV = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if hif();

  hazard_ctrl #(.DIV_CYCLES(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif.slave)
  );

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;

  // Reference state: divider modelled as a start timestamp, not a counter.
  bit divActive = 1'b0;
  int divT0     = 0;
  bit pend      = 1'b0;

  typedef struct packed {
    logic [1:0] faE, fbE;
    logic       faD, fbD;
    logic [4:0] stall;   // F D E M W
    logic [3:0] flush;   // D E M W
    logic       busy, done;
  } exp_t;

  logic [4:0] obsStall;
  logic [3:0] obsFlush;
  logic       obsBusy, obsDone;
  logic [1:0] obsFaE;

  task automatic chkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit writes(input logic we, input logic [4:0] wr, input logic [4:0] src);
    return we && wr != 0 && wr == src;
  endfunction

  function automatic logic [1:0] fwdE(input logic [4:0] src);
    if (writes(hif.reg_write_enM, hif.write_regM, src)) return 2'd2;
    if (writes(hif.reg_write_enW, hif.write_regW, src)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic exp_t model();
    exp_t e;
    bit lw, br, busyNow, doneNow, holdDiv, inE, inM;
    e = '0;
    if (rst) return e;
    e.faE = fwdE(hif.rsE);
    e.fbE = fwdE(hif.rtE);
    e.faD = writes(hif.reg_write_enM, hif.write_regM, hif.rsD);
    e.fbD = writes(hif.reg_write_enM, hif.write_regM, hif.rtD);
    inE = hif.reg_write_enE && hif.write_regE != 0 &&
          (hif.write_regE == hif.rsD || hif.write_regE == hif.rtD);
    inM = hif.mem_to_regM && hif.write_regM != 0 &&
          (hif.write_regM == hif.rsD || hif.write_regM == hif.rtD);
    lw = hif.mem_to_regE && inE;
    br = hif.branchD && (inE || inM);
    busyNow = divActive && cyc > divT0 && cyc <= divT0 + DIV;
    doneNow = divActive && cyc > divT0 + DIV;
    holdDiv = busyNow || (!divActive && hif.div_startE);
    e.busy = busyNow;
    e.done = doneNow;
    if (hif.except_M) begin
      e.flush = {~hif.i_stall, 3'b111};
      e.stall = {hif.i_stall, hif.i_stall, 3'b000};
    end else begin
      if (hif.i_stall || hif.d_stall) e.stall = 5'b11111;
      else if (holdDiv) begin e.stall = 5'b11100; e.flush = 4'b0010; end
      else if (lw || br) begin e.stall = 5'b11000; e.flush = 4'b0100; end
      if (pend && !hif.i_stall) begin e.flush[3] = 1'b1; e.stall[3] = 1'b0; end
    end
    return e;
  endfunction

  task automatic updateModel(input exp_t e);
    if (rst) begin
      divActive = 1'b0;
      pend      = 1'b0;
    end else if (hif.except_M) begin
      divActive = 1'b0;
      pend      = hif.i_stall;
    end else begin
      pend = pend && hif.i_stall;
      if (!divActive && hif.div_startE) begin
        divActive = 1'b1;
        divT0     = cyc;
      end else if (e.done && !e.stall[2]) begin
        divActive = 1'b0;
      end
    end
    cyc++;
  endtask

  // One clock: inputs already driven just after the previous rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    e = model();
    obsStall = {hif.stallF, hif.stallD, hif.stallE, hif.stallM, hif.stallW};
    obsFlush = {hif.flushD, hif.flushE, hif.flushM, hif.flushW};
    obsBusy  = hif.div_busy;
    obsDone  = hif.div_done;
    obsFaE   = hif.forward_aE;
    chkEq("fwdE",  {hif.forward_aE, hif.forward_bE}, {e.faE, e.fbE});
    chkEq("fwdD",  {hif.forward_aD, hif.forward_bD}, {e.faD, e.fbD});
    chkEq("stall", obsStall, e.stall);
    chkEq("flush", obsFlush, e.flush);
    chkEq("div",   {obsBusy, obsDone}, {e.busy, e.done});
    updateModel(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    hif.rsD = 0; hif.rtD = 0; hif.rsE = 0; hif.rtE = 0;
    hif.write_regE = 0; hif.write_regM = 0; hif.write_regW = 0;
    hif.branchD = 0; hif.reg_write_enE = 0; hif.reg_write_enM = 0;
    hif.reg_write_enW = 0; hif.mem_to_regE = 0; hif.mem_to_regM = 0;
    hif.div_startE = 0; hif.except_M = 0; hif.i_stall = 0; hif.d_stall = 0;
  endtask

  task automatic randInputs();
    hif.rsD = 5'($urandom_range(0, 3)); hif.rtD = 5'($urandom_range(0, 3));
    hif.rsE = 5'($urandom_range(0, 3)); hif.rtE = 5'($urandom_range(0, 3));
    hif.write_regE = 5'($urandom_range(0, 3));
    hif.write_regM = 5'($urandom_range(0, 3));
    hif.write_regW = 5'($urandom_range(0, 3));
    hif.branchD       = ($urandom_range(0, 2) == 0);
    hif.reg_write_enE = $urandom_range(0, 1) == 1;
    hif.reg_write_enM = $urandom_range(0, 1) == 1;
    hif.reg_write_enW = $urandom_range(0, 1) == 1;
    hif.mem_to_regE   = ($urandom_range(0, 2) == 0);
    hif.mem_to_regM   = ($urandom_range(0, 2) == 0);
    hif.div_startE    = ($urandom_range(0, 7) == 0);
    hif.except_M      = ($urandom_range(0, 39) == 0);
    hif.i_stall       = ($urandom_range(0, 5) == 0);
    hif.d_stall       = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    int busyCnt, stallECnt, doneAt, doneCnt, flushDCnt;

    // Reset state: everything low regardless of inputs.
    rst = 1'b1;
    randInputs();
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      chkEq("rstStall", obsStall, 5'b0);
      randInputs();
    end
    clearInputs();
    rst = 1'b0;
    step();

    // Forwarding: MEM beats WB; $0 never forwarded.
    hif.rsE = 5; hif.write_regM = 5; hif.write_regW = 5;
    hif.reg_write_enM = 1; hif.reg_write_enW = 1;
    step();
    chkEq("fwdMemWins", obsFaE, 2'b10);
    hif.rsE = 0; hif.write_regM = 0; hif.write_regW = 0;
    step();
    chkEq("fwdZero", obsFaE, 2'b00);
    clearInputs();

    // Load-use: one bubble, then the load sits in MEM and no stall remains.
    hif.mem_to_regE = 1; hif.reg_write_enE = 1; hif.write_regE = 8; hif.rtD = 8;
    step();
    chkEq("lwStall", {obsStall, obsFlush}, {5'b11000, 4'b0100});
    clearInputs();
    hif.rtE = 8; hif.mem_to_regM = 1; hif.reg_write_enM = 1; hif.write_regM = 8;
    step();
    chkEq("lwAfter", {obsStall, obsFlush}, 9'b0);
    clearInputs();

    // Divider timeline with the instruction held in EX until it advances.
    busyCnt = 0; stallECnt = 0; doneAt = -1;
    hif.div_startE = 1;
    for (int k = 0; k < DIV + 4; k++) begin
      step();
      busyCnt   += obsBusy;
      stallECnt += obsStall[2];
      if (obsDone && doneAt < 0) doneAt = k;
      if (obsDone) hif.div_startE = 0;
    end
    chkEq("divBusyCnt", busyCnt, DIV);
    chkEq("divStallE", stallECnt, DIV + 1);
    chkEq("divDoneAt", doneAt, DIV + 1);
    clearInputs();

    // Memory wait during BUSY and across the end of the count.
    doneAt = -1; doneCnt = 0;
    hif.div_startE = 1;
    for (int k = 0; k < DIV + 6; k++) begin
      hif.d_stall = (k >= 5 && k < 8) || (k >= DIV - 1 && k < DIV + 3);
      step();
      if (k >= 5 && k < 8) chkEq("dStallBusy", {obsStall, obsFlush}, {5'b11111, 4'b0});
      if (obsDone && doneAt < 0) doneAt = k;
      doneCnt += obsDone;
      if (obsDone && !obsStall[2]) hif.div_startE = 0;
    end
    chkEq("dStallDoneAt", doneAt, DIV + 1);
    chkEq("dStallDoneHold", doneCnt, 3);
    clearInputs();

    // Exception with an outstanding fetch: ID flush deferred, issued once.
    flushDCnt = 0;
    hif.except_M = 1; hif.i_stall = 1;
    step();
    chkEq("excFlush", obsFlush, 4'b0111);
    hif.except_M = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      flushDCnt += obsFlush[3];
    end
    hif.i_stall = 0;
    step();
    chkEq("excDeferred", obsFlush[3], 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      flushDCnt += obsFlush[3];
    end
    chkEq("excFlushDOnce", flushDCnt, 0);

    // Reset mid-BUSY aborts at once and never produces a done pulse.
    hif.div_startE = 1;
    for (int k = 0; k < 10; k++) step();
    rst = 1'b1;
    #1;
    chkEq("rstAsyncBusy", hif.div_busy, 1'b0);
    hif.div_startE = 0;
    step();
    step();
    rst = 1'b0;
    doneCnt = 0;
    for (int k = 0; k < DIV + 6; k++) begin
      step();
      doneCnt += obsDone;
    end
    chkEq("rstNoDone", doneCnt, 0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      randInputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
